// File: rtl/dpram_fifo_ctrl_if.sv
// ----------------------------------------------------------------------------
// dpram_fifo_ctrl_if
// User-side bus of the dual-port-RAM FIFO controller.
//   push/wr_data : write request and its data
//   pop          : read request
//   rd_data      : pop data, meaningful only while rd_valid=1
//   rd_valid     : one-cycle strobe, one cycle after an accepted pop
//   full/empty   : occupancy flags
//   level        : occupancy 0..2**aw (tied to 0 unless DPRAM_FIFO_LEVEL_EN)
// Modports: master = FIFO user, slave = FIFO controller.
// ----------------------------------------------------------------------------
interface dpram_fifo_ctrl_if #(
  parameter int aw = 5,
  parameter int dw = 16
);
  logic          push;
  logic [dw-1:0] wr_data;
  logic          pop;
  logic [dw-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic [aw:0]   level;

  modport master (
    output push, wr_data, pop,
    input  rd_data, rd_valid, full, empty, level
  );

  modport slave (
    input  push, wr_data, pop,
    output rd_data, rd_valid, full, empty, level
  );
endinterface

// File: rtl/dpram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// dpram_fifo_ctrl
// FIFO controller driving an external dual-port RAM with a registered read
// port. Depth is 2**aw words of dw bits.
// Ports:
//   clk, rst    : single rising-edge clock, synchronous active-high reset
//   fifo        : user bus (dpram_fifo_ctrl_if.slave)
//   ram_wrst/ram_rrst            : RAM port resets (follow rst)
//   ram_wce/ram_we/ram_waddr/ram_di : RAM write port
//   ram_rce/ram_oe/ram_raddr/ram_do : RAM read port (ram_do one cycle late)
// Optional feature: define DPRAM_FIFO_LEVEL_EN to build the occupancy
// subtractor; otherwise level is tied to zero.
// ----------------------------------------------------------------------------
module dpram_fifo_ctrl #(
  parameter int aw = 5,
  parameter int dw = 16
) (
  input  logic              clk,
  input  logic              rst,
  dpram_fifo_ctrl_if.slave  fifo,
  output logic              ram_rrst,
  output logic              ram_wrst,
  output logic              ram_rce,
  output logic              ram_oe,
  output logic              ram_wce,
  output logic              ram_we,
  output logic [aw-1:0]     ram_raddr,
  output logic [aw-1:0]     ram_waddr,
  output logic [dw-1:0]     ram_di,
  input  logic [dw-1:0]     ram_do
);

  localparam logic [aw:0] ptr_one = {{aw{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [aw:0] wr_ptr_reg, wr_ptr_next;
  logic [aw:0] rd_ptr_reg, rd_ptr_next;
  logic        rd_valid_reg, rd_valid_next;

  logic        full, empty;
  logic        push_ok, pop_ok;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[aw-1:0] == rd_ptr_reg[aw-1:0]) &&
                 (wr_ptr_reg[aw] != rd_ptr_reg[aw]);

  // Acceptance uses the flags as they stand before the edge, so a push into
  // a full FIFO is dropped even when a pop frees a slot in the same cycle.
  assign push_ok = fifo.push && !full;
  assign pop_ok  = fifo.pop && !empty;

  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    rd_valid_next = pop_ok;
    if (push_ok) wr_ptr_next = wr_ptr_reg + ptr_one;
    if (pop_ok)  rd_ptr_next = rd_ptr_reg + ptr_one;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      rd_valid_reg <= rd_valid_next;
    end
  end

  // RAM write port
  assign ram_wrst  = rst;
  assign ram_wce   = push_ok && !rst;
  assign ram_we    = push_ok && !rst;
  assign ram_waddr = wr_ptr_reg[aw-1:0];
  assign ram_di    = fifo.wr_data;

  // RAM read port. The enable stays up during the rd_valid cycle; a read
  // done then without a new pop may hit the word being written, but its
  // result lands after rd_valid has dropped and is never presented.
  assign ram_rrst  = rst;
  assign ram_rce   = (pop_ok || rd_valid_reg) && !rst;
  assign ram_oe    = rd_valid_reg;
  assign ram_raddr = rd_ptr_reg[aw-1:0];

  // User side
  assign fifo.rd_data  = ram_do;
  assign fifo.rd_valid = rd_valid_reg;
  assign fifo.full     = full;
  assign fifo.empty    = empty;

`ifdef DPRAM_FIFO_LEVEL_EN
  // Modulo 2**(aw+1) difference of the registered pointers.
  assign fifo.level = wr_ptr_reg - rd_ptr_reg;
`else
  assign fifo.level = '0;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dpram_fifo_ctrl
// Self-checking bench for dpram_fifo_ctrl (aw=5, dw=16) with a behavioural
// dual-port RAM and a queue-based FIFO reference model.
// ----------------------------------------------------------------------------
module tb_dpram_fifo_ctrl;

  localparam int AW    = 5;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_rrst, ram_wrst, ram_rce, ram_oe, ram_wce, ram_we;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [DW-1:0] ram_di, ram_do;

  dpram_fifo_ctrl_if #(.aw(AW), .dw(DW)) bus ();

  dpram_fifo_ctrl #(.aw(AW), .dw(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .fifo     (bus),
    .ram_rrst (ram_rrst),
    .ram_wrst (ram_wrst),
    .ram_rce  (ram_rce),
    .ram_oe   (ram_oe),
    .ram_wce  (ram_wce),
    .ram_we   (ram_we),
    .ram_raddr(ram_raddr),
    .ram_waddr(ram_waddr),
    .ram_di   (ram_di),
    .ram_do   (ram_do)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM, registered read.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wce && ram_we) mem[ram_waddr] <= ram_di;
    if (ram_rce) ram_do <= mem[ram_raddr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of stored words plus counts of accepted ops.
  logic [DW-1:0] model_q[$];
  int            wr_cnt = 0;
  int            rd_cnt = 0;
  logic          exp_rv = 1'b0;
  logic [DW-1:0] exp_rd = '0;

  function automatic int exp_level();
`ifdef DPRAM_FIFO_LEVEL_EN
    return model_q.size();
`else
    return 0;
`endif
  endfunction

  task automatic cycle(input logic r, input logic p, input logic pp, input logic [DW-1:0] d);
    logic exp_push_ok, exp_pop_ok;
    @(negedge clk);
    rst = r; bus.push = p; bus.pop = pp; bus.wr_data = d;
    #1;
    exp_push_ok = p && (model_q.size() < DEPTH);
    exp_pop_ok  = pp && (model_q.size() > 0);
    chk("ram_rrst", 32'(ram_rrst), 32'(r));
    chk("ram_wrst", 32'(ram_wrst), 32'(r));
    if (r) begin
      chk("rst_ram_we", 32'(ram_we), 0);
      chk("rst_ram_wce", 32'(ram_wce), 0);
      chk("rst_ram_rce", 32'(ram_rce), 0);
    end else begin
      chk("empty", 32'(bus.empty), 32'(model_q.size() == 0));
      chk("full", 32'(bus.full), 32'(model_q.size() == DEPTH));
      chk("level", 32'(bus.level), 32'(exp_level()));
      chk("ram_we", 32'(ram_we), 32'(exp_push_ok));
      chk("ram_wce", 32'(ram_wce), 32'(exp_push_ok));
      chk("ram_rce", 32'(ram_rce), 32'(exp_pop_ok || exp_rv));
      chk("ram_oe", 32'(ram_oe), 32'(exp_rv));
      chk("ram_waddr", 32'(ram_waddr), 32'(wr_cnt % DEPTH));
      chk("ram_raddr", 32'(ram_raddr), 32'(rd_cnt % DEPTH));
      if (exp_push_ok) chk("ram_di", 32'(ram_di), 32'(d));
    end
    @(posedge clk);
    if (r) begin
      model_q.delete();
      wr_cnt = 0; rd_cnt = 0; exp_rv = 1'b0;
    end else begin
      exp_rv = exp_pop_ok;
      if (exp_pop_ok) begin exp_rd = model_q.pop_front(); rd_cnt++; end
      if (exp_push_ok) begin model_q.push_back(d); wr_cnt++; end
    end
    #1;
    chk("rd_valid", 32'(bus.rd_valid), 32'(exp_rv));
    if (exp_rv) begin
      chk("rd_data", 32'(bus.rd_data), 32'(exp_rd));
      chk("rd_data_known", 32'($isunknown(bus.rd_data)), 0);
    end
  endtask

  typedef struct {
    logic          push;
    logic          pop;
    logic [DW-1:0] data;
    logic          exp_rv;
    logic [DW-1:0] exp_rd;
    logic          exp_empty;
    logic          exp_full;
  } vec_t;

  vec_t tbl[8];

  initial begin
    rst = 1'b1; bus.push = 1'b0; bus.pop = 1'b0; bus.wr_data = '0;

    // Directed table: three pushes, three back-to-back pops, idle, empty pop.
    tbl[0] = '{1'b1, 1'b0, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 16'h2222, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 16'h3333, 1'b0, 16'h0000, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'h1111, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'h2222, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 16'h0000, 1'b1, 16'h3333, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};

    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    // Reset state
    @(negedge clk); rst = 1'b0;
    #1;
    chk("reset_empty", 32'(bus.empty), 1);
    chk("reset_full", 32'(bus.full), 0);
    chk("reset_level", 32'(bus.level), 0);
    chk("reset_rd_valid", 32'(bus.rd_valid), 0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.push = tbl[i].push; bus.pop = tbl[i].pop; bus.wr_data = tbl[i].data;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_rd_valid", i), 32'(bus.rd_valid), 32'(tbl[i].exp_rv));
      if (tbl[i].exp_rv) chk($sformatf("tbl%0d_rd_data", i), 32'(bus.rd_data), 32'(tbl[i].exp_rd));
      chk($sformatf("tbl%0d_empty", i), 32'(bus.empty), 32'(tbl[i].exp_empty));
      chk($sformatf("tbl%0d_full", i), 32'(bus.full), 32'(tbl[i].exp_full));
    end

    // Fill to full, then overflow push, then simultaneous push+pop at full.
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 1'b0, 16'(i));
    chk("full_after_fill", 32'(bus.full), 1);
    cycle(1'b0, 1'b1, 1'b0, 16'hFFFF);
    chk("overflow_waddr", 32'(ram_waddr), 0);
    cycle(1'b0, 1'b1, 1'b1, 16'hAAAA);
    chk("fullpp_rd_data", 32'(bus.rd_data), 0);
    chk("fullpp_full", 32'(bus.full), 0);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 1'b1, '0);
    chk("drained_empty", 32'(bus.empty), 1);

    // Push+pop while empty: pop ignored, push kept.
    cycle(1'b0, 1'b1, 1'b1, 16'h5A5A);
    chk("emptypp_no_valid", 32'(bus.rd_valid), 0);
    cycle(1'b0, 1'b0, 1'b1, '0);
    chk("emptypp_later_pop", 32'(bus.rd_data), 32'h5A5A);
    cycle(1'b0, 1'b0, 1'b0, '0);

    // Steady state at level 4 across pointer wraps.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 16'($urandom));
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 1'b1, 16'($urandom));
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, '0);

    // Reset at level 7: pop the cycle before reset, and a pop during reset.
    cycle(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 1'b0, 16'(16'h0700 + i));
    cycle(1'b0, 1'b0, 1'b1, '0);
    cycle(1'b1, 1'b0, 1'b1, '0);
    chk("midrst_rd_valid", 32'(bus.rd_valid), 0);
    cycle(1'b0, 1'b0, 1'b0, '0);
    chk("midrst_empty", 32'(bus.empty), 1);
    chk("midrst_level", 32'(bus.level), 0);

    // Random traffic against the model, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      logic r, p, pp;
      r  = ($urandom_range(0, 63) == 0);
      p  = ($urandom_range(0, 99) < 55);
      pp = ($urandom_range(0, 99) < 50);
      cycle(r, p, pp, 16'($urandom));
    end
    cycle(1'b0, 1'b0, 1'b0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
DPRAM_FIFO_CTRL -- requirements
Module: dpram_fifo_ctrl

Interface
REQ-001 Parameter aw, default 5, RAM address width; FIFO depth is 2**aw.
REQ-002 Parameter dw, default 16, data width.
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 push  input  1  write request; accepted only when full=0.
REQ-006 wr_data  input  dw  data written on an accepted push.
REQ-007 pop  input  1  read request; accepted only when empty=0.
REQ-008 rd_data  output  dw  pop data, valid only while rd_valid=1.
REQ-009 rd_valid  output  1  high for exactly one cycle, one cycle after each accepted pop.
REQ-010 full, empty  output  1 each  occupancy flags.
REQ-011 level  output  aw+1  current occupancy, 0..2**aw.
REQ-012 RAM side: ram_rrst, ram_wrst, ram_rce, ram_oe, ram_wce, ram_we  output  1 each; ram_raddr, ram_waddr  output  aw; ram_di  output  dw; ram_do  input  dw.

Function
REQ-013 push_ok = push & ~full; pop_ok = pop & ~empty; both are evaluated on pre-edge flags.
REQ-014 Write path: ram_wce = ram_we = push_ok, combinational; ram_waddr = wr_ptr; ram_di = wr_data; wr_ptr increments mod 2**aw on push_ok.
REQ-015 Read path: ram_raddr = rd_ptr; ram_rce = pop_ok | rd_valid; ram_oe = rd_valid; rd_ptr increments mod 2**aw on pop_ok.
REQ-016 rd_valid register = pop_ok of the previous cycle; rd_data = ram_do, passed through combinationally; latency from pop to data is 1 cycle.
REQ-017 Back-to-back pops on consecutive cycles produce rd_valid high on consecutive cycles, with data in FIFO order.
REQ-018 Collision rule: pop_ok and push_ok in the same cycle never address the same word, because equal pointers imply full or empty.
REQ-019 The rd_valid-only read (ram_rce=1, pop_ok=0) may return X from the RAM on an address collision; that value is never presented with rd_valid=1.
REQ-020 Pointers are aw+1 bits wide, with an extra wrap bit.
REQ-021 empty = (wr_ptr == rd_ptr).
REQ-022 full = (address bits equal) & (wrap bits differ).
REQ-023 Push while full is ignored: pointers do not move and ram_we=0, even if pop is accepted in the same cycle.
REQ-024 Pop while empty is ignored: rd_valid does not assert in the next cycle, even if push is accepted in the same cycle.
REQ-025 Simultaneous push_ok and pop_ok leave occupancy unchanged.
REQ-026 Pointer wrap from 2**aw-1 to 0 is seamless.

Reset
REQ-027 On rst=1 at a clock edge: wr_ptr=0, rd_ptr=0, rd_valid=0; after reset empty=1, full=0, level=0.
REQ-028 While rst=1: ram_we, ram_wce and ram_rce are forced to 0; ram_rrst = ram_wrst = rst.
REQ-029 Reset mid-operation discards all contents; a pop issued in the cycle before reset produces no rd_valid after reset.

Configuration
REQ-030 Macro DPRAM_FIFO_LEVEL_EN defined: level = wr_ptr - rd_ptr, computed modulo 2**(aw+1) and registered-pointer based, so it reflects the current cycle.
REQ-031 Macro DPRAM_FIFO_LEVEL_EN undefined: level is tied to 0, no subtractor is built, and all other behaviour is identical.

Verification
REQ-032 After reset, push 0x1111, 0x2222, 0x3333 on three cycles, then pop three times back-to-back -> rd_valid high for 3 consecutive cycles with rd_data 0x1111, 0x2222, 0x3333; empty=1 afterwards.
REQ-033 aw=5: push 32 words 0..31 -> full=1 and level=32 (LEVEL_EN defined); a 33rd push leaves ram_we=0 and pointers unchanged.
REQ-034 Full FIFO, push(0xAAAA) and pop in the same cycle -> pop returns word 0 next cycle, push ignored, full=0, level=31.
REQ-035 Empty FIFO, push(0x5A5A) and pop in the same cycle -> no rd_valid next cycle; empty=0 and level=1; a later pop returns 0x5A5A.
REQ-036 Run 100 push/pop pairs at level 4 -> pointers wrap with data order preserved; X never appears on rd_data while rd_valid=1.
REQ-037 Assert rst for one cycle at level 7 with a pop pending -> no rd_valid, empty=1, level=0; with LEVEL_EN undefined, level stays 0 throughout.
